// File: rtl/edge_detection_pkg.sv
// Shared constants and types for the edge-detection pipeline.
// Holds the frame geometry, the VGA 640x480 timing constants, the grey pixel
// type and the 3x3 window type used between the window generator and the
// Sobel gradient stage. There are no ports; this file only declares items.
package edge_detection_pkg;

    // Active frame geometry and pixel width
    localparam int unsigned H_PIXELS = 640;
    localparam int unsigned V_LINES  = 480;
    localparam int unsigned PIX_W    = 8;

    // VGA 640x480@60 timing (pixel clocks / lines)
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_TOTAL  = H_PIXELS + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_TOTAL  = V_LINES + V_FRONT + V_SYNC + V_BACK;

    // Window-centre coordinate widths
    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    typedef logic [PIX_W-1:0] pix_t;

    // [row][col]; row 0 is the oldest line, col 0 the oldest pixel.
    // Flattened, element 3*row+col sits at bits [(3*row+col)*PIX_W +: PIX_W].
    typedef pix_t [2:0][2:0] pix_window_t;

    // Drop column 0, move columns left and insert a new column at col 2.
    function automatic pix_window_t shift_column(
        input pix_window_t win,
        input pix_t        top,
        input pix_t        mid,
        input pix_t        bot
    );
        pix_window_t res;
        res = win;
        for (int r = 0; r < 3; r++) begin
            res[r][0] = win[r][1];
            res[r][1] = win[r][2];
        end
        res[0][2] = top;
        res[1][2] = mid;
        res[2][2] = bot;
        return res;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line buffer: one address, synchronous read with one cycle of
// latency and read-before-write on the same address. Kept as its own module
// so it can be replaced by a hard RAM macro. Contents are not reset.
// Ports:
//   clk   - clock, rising edge
//   en    - access enable (read, and write when we=1)
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (old contents when reading and writing)
module line_buffer_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-before-write access port
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 window generator between the greyscale stage and the Sobel stage.
// Tracks the raster position from DE/VSYNC, keeps the two previous lines in
// two line buffers and emits a 3x3 window plus its centre coordinates for
// every accepted pixel, two cycles after the pixel arrives. Sync signals are
// delayed by the same two cycles.
// Ports:
//   I_PCLK, I_RST           - pixel clock, asynchronous active-high reset
//   I_PIX, I_DE             - grey pixel and its data enable
//   I_HSYNC, I_VSYNC        - raster sync inputs
//   O_WIN                   - window, element 3*row+col at [k*PIX_W +: PIX_W]
//   O_WIN_VALID             - window lies fully inside the frame
//   O_X, O_Y                - window-centre column/row (held when invalid)
//   O_DE, O_HSYNC, O_VSYNC  - inputs delayed by two cycles
//   O_OVF                   - sticky: a line exceeded H_PIXELS DE cycles
module sobel_window_gen
    import edge_detection_pkg::PIX_W, edge_detection_pkg::X_W, edge_detection_pkg::Y_W;
    import edge_detection_pkg::pix_t, edge_detection_pkg::pix_window_t;
    import edge_detection_pkg::shift_column;
#(
    parameter int unsigned H_PIXELS  = edge_detection_pkg::H_PIXELS,
    parameter int unsigned V_LINES   = edge_detection_pkg::V_LINES,
    parameter logic        VS_ACTIVE = 1'b1
) (
    input  logic               I_PCLK,
    input  logic               I_RST,
    input  logic [PIX_W-1:0]   I_PIX,
    input  logic               I_DE,
    input  logic               I_HSYNC,
    input  logic               I_VSYNC,
    output logic [9*PIX_W-1:0] O_WIN,
    output logic               O_WIN_VALID,
    output logic [X_W-1:0]     O_X,
    output logic [Y_W-1:0]     O_Y,
    output logic               O_DE,
    output logic               O_HSYNC,
    output logic               O_VSYNC,
    output logic               O_OVF
);

    localparam int unsigned CW = $clog2(H_PIXELS + 1);
    localparam int unsigned RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned AW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;

    // Raster position and edge detectors
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          de_prev;
    logic          vs_prev;
    logic          bank;

    logic          frame_start;
    logic          col_full;
    logic          accept;
    logic [AW-1:0] addr;

    // Stage 1: pixel and position aligned with the RAM read data
    logic          acc_d1;
    pix_t          pix_d1;
    logic [CW-1:0] col_d1;
    logic [RW-1:0] row_d1;
    logic          bank_d1;
    logic          de_d1;
    logic          hs_d1;
    logic          vs_d1;

    pix_t          rd_a;
    pix_t          rd_b;
    pix_t          two_back;
    pix_t          one_back;
    logic          win_ok;
    pix_window_t   win_q;

    assign frame_start = (I_VSYNC == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
    assign col_full    = (col == CW'(H_PIXELS));
    // A frame start abandons whatever pixel arrives in the same cycle
    assign accept      = I_DE && !col_full && !frame_start;
    assign addr        = AW'(col);

    // Position counters, line-bank toggle and sticky overflow
    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            col     <= '0;
            row     <= '0;
            bank    <= 1'b0;
            O_OVF   <= 1'b0;
            de_prev <= 1'b0;
            vs_prev <= ~VS_ACTIVE;
        end else begin
            de_prev <= I_DE;
            vs_prev <= I_VSYNC;
            if (frame_start) begin
                col   <= '0;
                row   <= '0;
                bank  <= 1'b0;
                O_OVF <= 1'b0;
            end else if (I_DE) begin
                if (col_full) begin
                    O_OVF <= 1'b1;
                end else begin
                    col <= col + CW'(1);
                end
            end else if (de_prev) begin
                col  <= '0;
                bank <= ~bank;
                if (row != RW'(V_LINES - 1)) begin
                    row <= row + RW'(1);
                end
            end
        end
    end

    // The two buffers alternate roles every line: the one being written
    // returns the line two back (read-before-write), the other one returns
    // the previous line. Each RAM therefore needs only one address per cycle.
    line_buffer_ram #(
        .DEPTH (H_PIXELS),
        .WIDTH (PIX_W)
    ) u_lb_a (
        .clk   (I_PCLK),
        .en    (accept),
        .we    (accept && !bank),
        .addr  (addr),
        .wdata (I_PIX),
        .rdata (rd_a)
    );

    line_buffer_ram #(
        .DEPTH (H_PIXELS),
        .WIDTH (PIX_W)
    ) u_lb_b (
        .clk   (I_PCLK),
        .en    (accept),
        .we    (accept && bank),
        .addr  (addr),
        .wdata (I_PIX),
        .rdata (rd_b)
    );

    // Stage 1 pipeline
    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            acc_d1  <= 1'b0;
            pix_d1  <= '0;
            col_d1  <= '0;
            row_d1  <= '0;
            bank_d1 <= 1'b0;
            de_d1   <= 1'b0;
            hs_d1   <= 1'b0;
            vs_d1   <= 1'b0;
        end else begin
            acc_d1  <= accept;
            pix_d1  <= I_PIX;
            col_d1  <= col;
            row_d1  <= row;
            bank_d1 <= bank;
            de_d1   <= I_DE;
            hs_d1   <= I_HSYNC;
            vs_d1   <= I_VSYNC;
        end
    end

    assign two_back = bank_d1 ? rd_b : rd_a;
    assign one_back = bank_d1 ? rd_a : rd_b;
    assign win_ok   = acc_d1 && (col_d1 >= CW'(2)) && (row_d1 >= RW'(2));

    // Stage 2: window shift, validity, centre coordinates and sync outputs
    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            win_q       <= '0;
            O_WIN_VALID <= 1'b0;
            O_X         <= '0;
            O_Y         <= '0;
            O_DE        <= 1'b0;
            O_HSYNC     <= 1'b0;
            O_VSYNC     <= 1'b0;
        end else begin
            O_DE        <= de_d1;
            O_HSYNC     <= hs_d1;
            O_VSYNC     <= vs_d1;
            O_WIN_VALID <= win_ok;
            if (acc_d1) begin
                win_q <= shift_column(win_q, two_back, one_back, pix_d1);
            end
            if (win_ok) begin
                O_X <= X_W'(col_d1) - X_W'(1);
                O_Y <= Y_W'(row_d1) - Y_W'(1);
            end
        end
    end

    assign O_WIN = win_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a reduced 16x10 frame.
// A behavioural model tracks the raster position and the last three lines
// as plain arrays and predicts every output two cycles ahead.
module tb_sobel_window_gen;

    localparam int H  = 16;
    localparam int V  = 10;
    localparam int HB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix;
    logic        de, hs, vs;
    logic [71:0] win;
    logic        win_valid;
    logic [9:0]  ox;
    logic [8:0]  oy;
    logic        ode, ohs, ovs, oovf;

    sobel_window_gen #(
        .H_PIXELS  (H),
        .V_LINES   (V),
        .VS_ACTIVE (1'b1)
    ) dut (
        .I_PCLK      (clk),
        .I_RST       (rst),
        .I_PIX       (pix),
        .I_DE        (de),
        .I_HSYNC     (hs),
        .I_VSYNC     (vs),
        .O_WIN       (win),
        .O_WIN_VALID (win_valid),
        .O_X         (ox),
        .O_Y         (oy),
        .O_DE        (ode),
        .O_HSYNC     (ohs),
        .O_VSYNC     (ovs),
        .O_OVF       (oovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic        valid;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [71:0] w;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] e0;
        logic [7:0] e4;
        logic [7:0] e8;
    } probe_t;

    int checks   = 0;
    int failures = 0;

    exp_t       exp1, exp2;
    int         m_r, m_c, m_lx, m_ly;
    bit         m_ovf, m_pde, m_pvs;
    logic [7:0] cur [H];
    logic [7:0] h1  [H];
    logic [7:0] h2  [H];

    int          cap_mode;
    logic [71:0] cap1 [V][H];
    logic [71:0] cap2 [V][H];
    int          valid_cnt, de_cnt;
    bit          fv_seen;
    logic [9:0]  fv_x;
    logic [8:0]  fv_y;

    probe_t probes [5];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        z.de = 0; z.hs = 0; z.vs = 0; z.valid = 0; z.x = '0; z.y = '0; z.w = '0;
        exp1 = z; exp2 = z;
        m_r = 0; m_c = 0; m_lx = 0; m_ly = 0;
        m_ovf = 0; m_pde = 0; m_pvs = 0;
    endtask

    // Spec-level model: position rules plus the last three lines as arrays
    task automatic model_step(input logic d, input logic h, input logic v, input logic [7:0] p);
        exp_t       e;
        logic [7:0] px;
        e.de = d; e.hs = h; e.vs = v; e.valid = 0; e.w = '0;
        if (v && !m_pvs) begin
            m_r = 0; m_c = 0; m_ovf = 0;
        end else if (d) begin
            if (m_c == H) begin
                m_ovf = 1;
            end else begin
                cur[m_c] = p;
                if (m_r >= 2 && m_c >= 2) begin
                    e.valid = 1;
                    m_lx = m_c - 1;
                    m_ly = m_r - 1;
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            if (i == 0)      px = h2[m_c - 2 + j];
                            else if (i == 1) px = h1[m_c - 2 + j];
                            else             px = cur[m_c - 2 + j];
                            e.w[(3*i + j)*8 +: 8] = px;
                        end
                    end
                end
                m_c++;
            end
        end else if (m_pde) begin
            m_c = 0;
            if (m_r < V - 1) m_r++;
            h2 = h1;
            h1 = cur;
        end
        e.x = 10'(m_lx);
        e.y = 9'(m_ly);
        m_pde = d;
        m_pvs = v;
        exp2 = exp1;
        exp1 = e;
    endtask

    task automatic check_outputs();
        chk("o_de",        72'(ode),       72'(exp2.de));
        chk("o_hsync",     72'(ohs),       72'(exp2.hs));
        chk("o_vsync",     72'(ovs),       72'(exp2.vs));
        chk("o_win_valid", 72'(win_valid), 72'(exp2.valid));
        chk("o_x",         72'(ox),        72'(exp2.x));
        chk("o_y",         72'(oy),        72'(exp2.y));
        chk("o_ovf",       72'(oovf),      72'(m_ovf));
        if (exp2.valid) chk("o_win", win, exp2.w);
        if (win_valid) begin
            valid_cnt++;
            if (!fv_seen) begin
                fv_seen = 1; fv_x = ox; fv_y = oy;
            end
            if (int'(oy) < V && int'(ox) < H) begin
                if (cap_mode == 1) cap1[oy][ox] = win;
                if (cap_mode == 2) cap2[oy][ox] = win;
            end
        end
        if (ode) de_cnt++;
    endtask

    task automatic cyc(input logic d, input logic h, input logic v, input logic [7:0] p);
        @(negedge clk);
        check_outputs();
        de = d; hs = h; vs = v; pix = p;
        model_step(d, h, v, p);
    endtask

    task automatic hblank(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, (k >= 2 && k < 5), 1'b0, 8'h00);
    endtask

    task automatic blank_line(input logic v);
        for (int k = 0; k < H + HB; k++) cyc(1'b0, (k >= 2 && k < 5), v, 8'h00);
    endtask

    task automatic ramp_line(input int r, input int len);
        for (int c = 0; c < len; c++) cyc(1'b1, 1'b0, 1'b0, 8'((r*3 + c) & 255));
        hblank(HB);
    endtask

    task automatic frame(input int nlines, input int ovf_line, input int abort_line,
                         input int abort_col, input bit rnd);
        int len;
        logic [7:0] p;
        blank_line(1'b1);
        blank_line(1'b1);
        blank_line(1'b0);
        for (int r = 0; r < nlines; r++) begin
            len = (r == ovf_line) ? H + 5 : H;
            for (int c = 0; c < len; c++) begin
                if (r == abort_line && c == abort_col) return;
                p = rnd ? 8'($urandom) : 8'((r*3 + c) & 255);
                cyc(1'b1, 1'b0, 1'b0, p);
            end
            hblank(rnd ? int'($urandom_range(10, 6)) : HB);
        end
    endtask

    task automatic check_probes(input int which);
        logic [71:0] w;
        for (int i = 0; i < 5; i++) begin
            w = (which == 1) ? cap1[probes[i].y][probes[i].x] : cap2[probes[i].y][probes[i].x];
            chk($sformatf("probe%0d_%0d_e0", which, i), 72'(w[7:0]),   72'(probes[i].e0));
            chk($sformatf("probe%0d_%0d_e4", which, i), 72'(w[39:32]), 72'(probes[i].e4));
            chk($sformatf("probe%0d_%0d_e8", which, i), 72'(w[71:64]), 72'(probes[i].e8));
        end
    endtask

    initial begin
        // Ramp P(r,c) = 3r+c; centre (x,y) -> e0=P(y-1,x-1), e4=P(y,x), e8=P(y+1,x+1)
        probes[0] = '{x: 1,  y: 1, e0: 8'd0,  e4: 8'd4,  e8: 8'd8};
        probes[1] = '{x: 5,  y: 3, e0: 8'd10, e4: 8'd14, e8: 8'd18};
        probes[2] = '{x: 14, y: 8, e0: 8'd34, e4: 8'd38, e8: 8'd42};
        probes[3] = '{x: 14, y: 1, e0: 8'd13, e4: 8'd17, e8: 8'd21};
        probes[4] = '{x: 1,  y: 8, e0: 8'd21, e4: 8'd25, e8: 8'd29};

        cap_mode = 0; valid_cnt = 0; de_cnt = 0; fv_seen = 0; fv_x = '0; fv_y = '0;
        rst = 1'b1; de = 1'b1; hs = 1'b0; vs = 1'b0; pix = 8'h55;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_win",   win,            72'(0));
        chk("rst_valid", 72'(win_valid), 72'(0));
        chk("rst_x",     72'(ox),        72'(0));
        chk("rst_y",     72'(oy),        72'(0));
        chk("rst_de",    72'(ode),       72'(0));
        chk("rst_hs",    72'(ohs),       72'(0));
        chk("rst_vs",    72'(ovs),       72'(0));
        chk("rst_ovf",   72'(oovf),      72'(0));

        @(negedge clk);
        rst = 1'b0; de = 1'b0; pix = 8'h00;
        model_step(1'b0, 1'b0, 1'b0, 8'h00);

        // Partial frame, then an asynchronous reset in the middle of a line
        for (int r = 0; r < 4; r++) ramp_line(r, H);
        for (int c = 0; c < 7; c++) cyc(1'b1, 1'b0, 1'b0, 8'((12 + c) & 255));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 72'(win_valid), 72'(0));
        chk("async_rst_de",    72'(ode),       72'(0));
        chk("async_rst_x",     72'(ox),        72'(0));
        chk("async_rst_win",   win,            72'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            de = 1'b1; pix = 8'(k);
            chk("in_rst_de",  72'(ode),       72'(0));
            chk("in_rst_valid", 72'(win_valid), 72'(0));
        end
        @(negedge clk);
        rst = 1'b0; de = 1'b0; pix = 8'h00;
        model_reset();
        fv_seen = 0;
        model_step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < 3; r++) ramp_line(r, H);
        chk("first_valid_seen", 72'(fv_seen), 72'(1));
        chk("first_valid_x",    72'(fv_x),    72'(1));
        chk("first_valid_y",    72'(fv_y),    72'(1));

        // Clean ramp frame
        cap_mode = 1; valid_cnt = 0; de_cnt = 0;
        frame(V, -1, -1, -1, 1'b0);
        cap_mode = 0;
        chk("valid_count", 72'(valid_cnt), 72'((H-2)*(V-2)));
        chk("de_count",    72'(de_cnt),    72'(H*V));
        check_probes(1);

        // Overflow on line 3, sticky until the next frame start
        frame(V, 3, -1, -1, 1'b0);
        chk("ovf_sticky", 72'(oovf), 72'(1));
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf_cleared", 72'(oovf), 72'(0));

        // VSYNC mid-line, then a ramp frame that must match the clean one
        frame(V, -1, 4, 10, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cap_mode = 2; valid_cnt = 0; de_cnt = 0;
        frame(V, -1, -1, -1, 1'b0);
        cap_mode = 0;
        chk("valid_count2", 72'(valid_cnt), 72'((H-2)*(V-2)));
        chk("de_count2",    72'(de_cnt),    72'(H*V));
        check_probes(2);

        // Random pixels and blanking, extra lines past V, one overflow line
        for (int f = 0; f < 4; f++) begin
            frame((f % 2 == 1) ? V + 2 : V, (f == 2) ? 5 : -1, -1, -1, 1'b1);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
